vliw_hazard_ctrl: RTL
=====================

Name: vliw_hazard_ctrl

Overview:
Issue and hazard controller for the 4-slot (A0, A1, M, LS) decode stage.
- Keeps a per-register scoreboard of pending load results.
- Detects load-use hazards for all 8 source operands of the bundle in ID. On a hazard it stalls IF/ID and injects a NOP bundle into EX.
- Sequences a fixed-length IF/ID flush after a jump misprediction reported by decode.
- Sits beside the decode stage. It drives the IF/ID pipeline-register enables and the EX-stage bubble select.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- TAGW, 5, register tag width; NREG = 2**TAGW.
- LOAD_LAT, 1, stall cycles a dependent bundle directly behind a load must wait before the memory-stage forward is valid (legal 1..3).
- FLUSH_CYC, 2, cycles the flush is held after a misprediction (legal 1..3).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  a bundle is present in ID.
- src_tags  in  8*TAGW  packed {a0_R0,a0_R1,a1_R0,a1_R1,m_R0,m_R1,ls_R0,ls_R1} source tags; a0_R0 occupies the MSBs.
- src_used  in  8  per-source read enable, same bit order as src_tags (bit 7 = a0_R0).
- ls_load  in  1  LS slot of the ID bundle is a load.
- ls_rd_tag  in  TAGW  destination tag of the LS load.
- mis_pred  in  1  decode reports a mispredicted jump in the ID bundle (predRW).
- issue  out  1  ID bundle advances to EX this cycle.
- stall_if  out  1  hold the PC and IF/ID register.
- stall_id  out  1  hold the ID bundle.
- bubble_ex  out  1  load a NOP bundle into EX.
- flush_ifid  out  1  invalidate the IF/ID register.
- state  out  2  0 = RUN, 1 = STALL, 2 = FLUSH.
- stall_count  out  16  saturating count of hazard-stall cycles.

Behaviour:
- Reset (rst_n = 0 at a clk edge): all scoreboard counters clear to 0; state = RUN; flush counter = 0; stall_count = 0.
- While reset is held, every combinational output reads 0 (issue, stall_if, stall_id, bubble_ex, flush_ifid).
- Reset mid-stall or mid-flush aborts it in that cycle.

Scoreboard:
- One 2-bit down-counter cnt[r] per register r = 1..NREG-1. Register 0 has no counter and never hazards.
- Every cycle each nonzero cnt decrements by 1.
- When issue = 1, ls_load = 1 and ls_rd_tag != 0, then cnt[ls_rd_tag] <= LOAD_LAT. The set wins over a decrement of the same entry.
- Counters keep decrementing during STALL and FLUSH.

Hazard, combinational from registered cnt and current inputs:
- hazard = id_valid & (state != FLUSH) & OR over i of (src_used[i] & src_tag[i] != 0 & cnt[src_tag[i]] != 0).
- A load whose ls_rd_tag equals a source of its own bundle is not a hazard; the source reads the old value.
- Writes from the A0, A1 and M slots are never scoreboarded; their results are covered by EX/MEM forwarding.

Outputs, all combinational:
- issue = id_valid & ~hazard & (state != FLUSH).
- stall_if = stall_id = bubble_ex = hazard.
- flush_ifid = (state == FLUSH).
- Net effect: a dependent bundle directly after a load stalls exactly LOAD_LAT cycles, then issues.

FSM (registered):
- RUN → STALL when hazard.
- RUN → FLUSH when issue & mis_pred; flush counter <= FLUSH_CYC - 1.
- STALL → RUN when ~hazard, except STALL → FLUSH when issue & mis_pred.
- STALL is a status state only; stalling is driven solely by hazard.
- FLUSH: bundles in ID are ignored (no issue, no scoreboard set, mis_pred ignored).
- FLUSH: the flush counter decrements each cycle; at 0 the FSM returns to RUN, so flush_ifid is asserted for exactly FLUSH_CYC cycles.
- mis_pred is sampled only on an issuing bundle. A stalled bundle's mis_pred takes effect in the cycle it finally issues.

stall_count:
- +1 on every cycle with hazard = 1.
- Saturates at 16'hFFFF.

Test Plan:
- Reset: rst_n = 0 for 2 cycles with id_valid = 1 → state = 0, stall_count = 0, issue = 0, all stall/flush outputs 0; release → issue = 1 for an independent bundle.
- Load-use: cycle t issue LS load to R3; cycle t+1 bundle with a1_R0 = 3 used → stall_if = stall_id = bubble_ex = 1 for exactly 1 cycle (LOAD_LAT = 1), issue at t+2, stall_count = 1.
- LOAD_LAT = 3 build, same sequence → 3 stall cycles, state = 1 during cycles t+2..t+4, stall_count = 3.
- Non-hazards: load to R0 followed by a read of R0; a source of R3 with src_used bit = 0; a load to R3 whose own ls_R0 = 3 → no stall in any case.
- Misprediction: issue a bundle with mis_pred = 1 → flush_ifid = 1 for 2 cycles, issue = 0 and no scoreboard update (a load issued in ID during flush sets no counter), then RUN.
- Stalled mispredict: bundle with mis_pred = 1 depends on the prior load → 1 stall cycle, then issue, then 2 flush cycles; assert rst_n = 0 during the flush → RUN next cycle, flush_ifid = 0.

Source files
------------

// File: rtl/vliw_hazard_ctrl_if.sv
// vliw_hazard_ctrl_if
//   Bundle of signals between the decode stage and the issue/hazard controller.
//   master : decode side. It drives the ID bundle description and reads the control outputs.
//   slave  : hazard controller side.
//   Signals:
//     id_valid, src_tags[8*TAGW], src_used[8], ls_load, ls_rd_tag[TAGW], mis_pred  (decode -> ctrl)
//     issue, stall_if, stall_id, bubble_ex, flush_ifid, state[2], stall_count[16]  (ctrl -> pipe)
interface vliw_hazard_ctrl_if #(
  parameter int TAGW = 5
);
  logic              id_valid;
  logic [8*TAGW-1:0] src_tags;
  logic [7:0]        src_used;
  logic              ls_load;
  logic [TAGW-1:0]   ls_rd_tag;
  logic              mis_pred;
  logic              issue;
  logic              stall_if;
  logic              stall_id;
  logic              bubble_ex;
  logic              flush_ifid;
  logic [1:0]        state;
  logic [15:0]       stall_count;

  modport master (
    output id_valid, src_tags, src_used, ls_load, ls_rd_tag, mis_pred,
    input  issue, stall_if, stall_id, bubble_ex, flush_ifid, state, stall_count
  );

  modport slave (
    input  id_valid, src_tags, src_used, ls_load, ls_rd_tag, mis_pred,
    output issue, stall_if, stall_id, bubble_ex, flush_ifid, state, stall_count
  );
endinterface

// File: rtl/vliw_hazard_ctrl.sv
// vliw_hazard_ctrl
//   Issue and hazard controller for the 4-slot (A0, A1, M, LS) VLIW decode stage.
//   It keeps a per-register scoreboard of pending load results and stalls IF/ID on a load-use hazard.
//   While IF/ID is stalled it injects a NOP bundle into EX.
//   After an issued mispredicted jump it holds an IF/ID flush for FLUSH_CYC cycles.
//   Ports:
//     i_clk    : system clock, rising edge
//     i_rst_n  : synchronous active-low reset (while low, all combinational outputs read 0)
//     hz       : vliw_hazard_ctrl_if.slave (ID bundle in, pipeline control out)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   RUN   | normal issue
//   STALL | status only: a load-use hazard held ID on the previous cycle
//   FLUSH | IF/ID flush after a mispredict; ID bundles are ignored
module vliw_hazard_ctrl #(
  parameter int NREG      = 32,
  parameter int TAGW      = 5,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  vliw_hazard_ctrl_if.slave hz
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Entry 0 exists only to keep indexing simple; it is held at 0.
  logic [1:0]  r_cnt [NREG];
  logic [1:0]  r_state;
  logic [1:0]  r_flush_cnt;
  logic [15:0] r_stall_count;

  logic [7:0]  w_src_hit;
  logic        w_flush;
  logic        w_hazard;
  logic        w_issue;
  logic        w_set;

  always_comb begin
    w_src_hit = '0;
    for (int i = 0; i < 8; i++) begin
      w_src_hit[i] = hz.src_used[i]
                   && (hz.src_tags[i*TAGW +: TAGW] != '0)
                   && (r_cnt[hz.src_tags[i*TAGW +: TAGW]] != 2'd0);
    end
  end

  assign w_flush  = (r_state == ST_FLUSH);
  // Outputs are gated with reset so nothing leaks while reset is held.
  assign w_hazard = i_rst_n & hz.id_valid & ~w_flush & (|w_src_hit);
  assign w_issue  = i_rst_n & hz.id_valid & ~w_flush & ~w_hazard;
  assign w_set    = w_issue & hz.ls_load & (hz.ls_rd_tag != '0);

  assign hz.issue       = w_issue;
  assign hz.stall_if    = w_hazard;
  assign hz.stall_id    = w_hazard;
  assign hz.bubble_ex   = w_hazard;
  assign hz.flush_ifid  = i_rst_n & w_flush;
  assign hz.state       = r_state;
  assign hz.stall_count = r_stall_count;

  // Scoreboard: a fresh load set overrides the per-cycle decrement.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= 2'd0;
    end else begin
      r_cnt[0] <= 2'd0;
      for (int r = 1; r < NREG; r++) begin
        if (w_set && (hz.ls_rd_tag == TAGW'(r)))
          r_cnt[r] <= 2'(LOAD_LAT);
        else if (r_cnt[r] != 2'd0)
          r_cnt[r] <= r_cnt[r] - 2'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 2'd0;
    end else begin
      case (r_state)
        ST_RUN, ST_STALL: begin
          // A stalled bundle's mis_pred only counts once it actually issues.
          if (w_issue && hz.mis_pred) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= 2'(FLUSH_CYC - 1);
          end else if (w_hazard) begin
            r_state <= ST_STALL;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (r_flush_cnt == 2'd0) r_state <= ST_RUN;
          else                     r_flush_cnt <= r_flush_cnt - 2'd1;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_stall_count <= 16'd0;
    else if (w_hazard && (r_stall_count != 16'hFFFF))
      r_stall_count <= r_stall_count + 16'd1;
  end

endmodule
